seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative signed two's-complement divider, the inverse operation of the team's combinational signed multiplier.
- Computes quotient and remainder of WIDTH-bit operands using restoring division on magnitudes, one quotient bit per clock.
- Uses a start/done handshake so the coprocessor datapath can issue element-wise divides without a wide combinational path.
- Flags divide-by-zero and signed overflow, consistent with the multiplier's ovf convention.

Parameters:
WIDTH, 8, operand/result width in bits (signed); latency scales as WIDTH+1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  signed dividend, captured on accepted start
b  input  WIDTH  signed divisor, captured on accepted start
quot  output  WIDTH  signed quotient, registered, held until next accepted start
rem  output  WIDTH  signed remainder, registered, held until next accepted start
busy  output  1  high in every state except IDLE
done  output  1  single-cycle pulse, results valid
ovf  output  1  quotient not representable (a = most negative, b = -1)
dz  output  1  divisor was zero

Behaviour:
- Reset (async, rst=1): state=IDLE; quot, rem, busy, done, ovf, dz all 0; internal counter, magnitudes and sign latches 0. Asserting rst mid-operation aborts immediately; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on edge with start=1:
  - capture |a| and |b| as unsigned WIDTH-bit magnitudes (|-128| = 128 fits unsigned).
  - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
  - latch dz = (b==0) and ovf = (a==min && b==-1); both flags clear at this edge when not true.
  - clear partial remainder; count=0; go to CALC.
  - start=0: stay in IDLE.
- CALC: each edge shifts one dividend bit (MSB first) into the partial remainder. If partial remainder >= |b|, subtract and set quotient bit = 1, else set quotient bit = 0. count++. After the WIDTH-th iteration (count==WIDTH-1 at the edge), go to FIX.
- FIX: on edge:
  - quot = sign_q ? -Q : Q; rem = sign_r ? -R : R (truncating division; remainder takes the dividend's sign).
  - Special cases override the arithmetic result:
    - dz: quot=0, rem=a.
    - ovf: quot=min (wrapped, 8'h80 for WIDTH=8), rem=0.
  - set done=1; go to DONE.
- DONE: done is high for exactly this one cycle; on next edge done=0, go to IDLE.
- Latency: start accepted at edge N → done=1 with valid quot/rem during the cycle after edge N+WIDTH+1 (edge N+9 for WIDTH=8). Latency is fixed, including for dz and ovf.
- busy: 1 from the edge after start acceptance through the DONE cycle, inclusive.
- start while busy (CALC/FIX/DONE) is ignored and not queued; a/b changes during busy have no effect.
- Back-to-back: earliest next accept is the edge that leaves DONE+1, i.e. the first edge in IDLE.
- Outputs hold their last values between operations; ovf/dz remain valid with the held result.

Optional Feature:
- Macro: DIV_SAT_EN
- Defined: saturating results.
  - ovf → quot = max (8'h7F), rem=0.
  - dz → quot = max if a>=0, else min; rem=a.
- Not defined: wrapped/zero results exactly as in Behaviour (ovf → min, dz → 0).
- Flags ovf and dz are identical in both builds.

Test Plan:
1. rst=1 for 10 ns, then start with a=-15 (8'hF1), b=2 → outputs 0 during reset; done pulse 9 cycles after accept; quot=8'hF9 (-7), rem=8'hFF (-1), ovf=0, dz=0; done high exactly 1 cycle.
2. a=-30 (8'hE2), b=2 → quot=8'hF1 (-15), rem=0. Then a=7, b=-2 → quot=8'hFD (-3), rem=1. Then a=4, b=4 → quot=1, rem=0.
3. a=-128 (8'h80), b=-1 (8'hFF) → ovf=1, dz=0, rem=0; quot=8'h80 without DIV_SAT_EN, 8'h7F with it.
4. a=16, b=0 → dz=1, ovf=0, rem=8'h10; quot=0 without macro, 8'h7F with it. a=-5, b=0 with macro → quot=8'h80.
5. Start a=100, b=7; re-pulse start with a=1, b=1 at cycle 3 → ignored; result quot=14, rem=2. Assert rst at cycle 5 of a new operation → immediate IDLE, all outputs 0, no done.
6. Back-to-back: start held high continuously with a=-100, b=9 → quot=-11 (8'hF5), rem=-1 (8'hFF); second accept occurs on the first edge in IDLE after DONE; done pulses spaced 11 cycles apart.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative signed divider, restoring division on magnitudes, one quotient bit per clock.
// Optional macro DIV_SAT_EN selects saturating results for overflow and divide-by-zero. Rev 1.0
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;

  // Partial remainder never exceeds |b|-1, so one extra bit covers the shifted value.
  assign w_shift = {prem_q, dvd_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, dvs_q});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    a_d        = a_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d      = a[WIDTH-1] ? -a : a;
          dvs_d      = b[WIDTH-1] ? -b : b;
          a_d        = a;
          sign_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          sign_rem_d = a[WIDTH-1];
          dz_d       = (b == '0);
          ovf_d      = (a == C_MIN) && (b == '1);
          prem_d     = '0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        prem_d = w_ge ? WIDTH'(w_shift - {1'b0, dvs_q}) : WIDTH'(w_shift);
        dvd_d  = {dvd_q[WIDTH-2:0], w_ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
`ifdef DIV_SAT_EN
          quot_d = a_q[WIDTH-1] ? C_MIN : C_MAX;
`else
          quot_d = '0;
`endif
          rem_d  = a_q;
        end else if (ovf_q) begin
`ifdef DIV_SAT_EN
          quot_d = C_MAX;
`else
          quot_d = C_MIN;
`endif
          rem_d  = '0;
        end else begin
          quot_d = sign_quo_q ? -dvd_q : dvd_q;
          rem_d  = sign_rem_q ? -prem_q : prem_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      a_q        <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      a_q        <= a_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference model.
`default_nettype none

module tb_seq_divider;

  localparam int W = 8;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
`ifdef DIV_SAT_EN
  localparam logic [W-1:0] E_OVF_Q   = 8'h7F;
  localparam logic [W-1:0] E_DZP_Q   = 8'h7F;
  localparam logic [W-1:0] E_DZN_Q   = 8'h80;
`else
  localparam logic [W-1:0] E_OVF_Q   = 8'h80;
  localparam logic [W-1:0] E_DZP_Q   = 8'h00;
  localparam logic [W-1:0] E_DZN_Q   = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] quot, rem;
  logic         busy, done, ovf, dz;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .quot (quot),
    .rem  (rem),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .dz   (dz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: truncating signed division with the special cases applied on top.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic o, output logic z);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    z  = (yi == 0);
    o  = (xi == -(1 << (W-1))) && (yi == -1);
    if (z) begin
`ifdef DIV_SAT_EN
      q = (xi >= 0) ? MAXV : MINV;
`else
      q = '0;
`endif
      r = x;
    end else if (o) begin
`ifdef DIV_SAT_EN
      q = MAXV;
`else
      q = MINV;
`endif
      r = '0;
    end else begin
      q = W'(xi / yi);
      r = W'(xi % yi);
    end
  endfunction

  // Model: an accepted operation occupies ten cycles; results appear in the last one.
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_ovf = 1'b0, m_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_q = '0; m_r = '0; m_ovf = 1'b0; m_dz = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        ref_div(a, b, p_q, p_r, m_ovf, m_dz);
        m_left = W + 2;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_q = p_q;
        m_r = p_r;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_left == 1));
    check("ovf",  32'(ovf),  32'(m_ovf));
    check("dz",   32'(dz),   32'(m_dz));
    check("quot", 32'(quot), 32'(m_q));
    check("rem",  32'(rem),  32'(m_r));
  end

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit glitch,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic eo, input logic ez, input string nm);
    int got;
    wait_idle();
    #1; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0; a = W'($urandom); b = W'($urandom);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin got = k; break; end
      if (glitch && k == 3) begin #1; start = 1'b1; a = 8'd1; b = 8'd1; end
      else if (glitch && k == 4) begin #1; start = 1'b0; end
    end
    check({nm, "_latency"}, 32'(got), 32'(W + 2));
    check({nm, "_quot"}, 32'(quot), 32'(eq));
    check({nm, "_rem"},  32'(rem),  32'(er));
    check({nm, "_ovf"},  32'(ovf),  32'(eo));
    check({nm, "_dz"},   32'(dz),   32'(ez));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return MINV;
      1: return '1;
      2: return '0;
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int seen, t1, t2;
    @(negedge clk);
    check("reset_quot", 32'(quot), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    #1; rst = 1'b0;

    run_op(8'hF1, 8'h02, 1'b0, 8'hF9, 8'hFF, 1'b0, 1'b0, "neg15_div2");
    run_op(8'hE2, 8'h02, 1'b0, 8'hF1, 8'h00, 1'b0, 1'b0, "neg30_div2");
    run_op(8'h07, 8'hFE, 1'b0, 8'hFD, 8'h01, 1'b0, 1'b0, "7_divneg2");
    run_op(8'h04, 8'h04, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, "4_div4");
    run_op(8'h80, 8'hFF, 1'b0, E_OVF_Q, 8'h00, 1'b1, 1'b0, "ovf");
    run_op(8'h10, 8'h00, 1'b0, E_DZP_Q, 8'h10, 1'b0, 1'b1, "dz_pos");
    run_op(8'hFB, 8'h00, 1'b0, E_DZN_Q, 8'hFB, 1'b0, 1'b1, "dz_neg");
    run_op(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 1'b0, "ignore_start");

    // Abort mid-operation with reset.
    wait_idle();
    #1; a = 8'h55; b = 8'h03; start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
    repeat (5) @(negedge clk);
    #1; rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_quot", 32'(quot), 32'd0);
    check("abort_rem",  32'(rem),  32'd0);
    check("abort_dz",   32'(dz),   32'd0);
    @(negedge clk);
    #1; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Back-to-back with start held high.
    #1; a = 8'h9C; b = 8'h09; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_quot", 32'(quot), 32'h0000_00F5);
        check("b2b_rem",  32'(rem),  32'h0000_00FF);
        if (t1 < 0) t1 = t;
        else begin t2 = t; break; end
      end
    end
    #1; start = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'd11);

    // Randomized traffic, including rare asynchronous aborts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) != 0);
      a     = pick();
      b     = pick();
    end
    #1; rst = 1'b0; start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
